rv32i_decoder: RTL and testbench

//  Combinational RV32I control decoder of the single-cycle core. Maps the 32-bit instruction and
//  the datapath compare flags to mux selects, ALU op, memory controls and register-write enable.

---
 rtl/rv32i_decoder.sv | 138 +++++++++++++
 tb/tb_rv32i_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decoder.sv
// RV32I control decoder for the single-cycle core.
// Purely combinational; reset forces the safe control vector.
module rv32i_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        equal,
  input  logic        less_than,
  input  logic        less_than_unsigned,
  output logic        pc_src,
  output logic        pc_target_src,
  output logic [1:0]  result_src,
  output logic        mem_write,
  output logic [2:0]  mem_width,
  output logic [3:0]  alu_control,
  output logic        alu_src,
  output logic [1:0]  immediate_control,
  output logic        reg_write
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_B  = 2'b10;
  localparam logic [1:0] IMM_UJ = 2'b11;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_TGT  = 2'b11;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_f7b5;
  logic       w_taken;
  logic       w_unused;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];
  assign w_f7b5   = instruction[30];
  assign w_unused = ^{clk, instruction};

  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_taken = equal;
      3'b001:  w_taken = ~equal;
      3'b100:  w_taken = less_than;
      3'b101:  w_taken = ~less_than;
      3'b110:  w_taken = less_than_unsigned;
      3'b111:  w_taken = ~less_than_unsigned;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_src            = 1'b0;
    pc_target_src     = 1'b0;
    result_src        = RES_ALU;
    mem_write         = 1'b0;
    mem_width         = 3'b010;
    alu_control       = ALU_ADD;
    alu_src           = 1'b0;
    immediate_control = IMM_I;
    reg_write         = 1'b0;
    if (!reset) begin
      case (w_opcode)
        OP_R: begin
          reg_write   = 1'b1;
          alu_control = {w_f7b5 & (w_funct3 == 3'b000 || w_funct3 == 3'b101),
                         w_funct3};
        end
        OP_I: begin
          reg_write   = 1'b1;
          alu_src     = 1'b1;
          // only shifts use bit 30; ADDI must never become SUB
          alu_control = {w_f7b5 & (w_funct3 == 3'b101), w_funct3};
        end
        OP_LOAD: begin
          reg_write  = 1'b1;
          alu_src    = 1'b1;
          result_src = RES_MEM;
          mem_width  = w_funct3;
        end
        OP_STORE: begin
          mem_write         = 1'b1;
          alu_src           = 1'b1;
          immediate_control = IMM_S;
          mem_width         = w_funct3;
        end
        OP_BRANCH: begin
          immediate_control = IMM_B;
          alu_control       = ALU_SUB;
          pc_src            = w_taken;
        end
        OP_JAL: begin
          pc_src            = 1'b1;
          immediate_control = IMM_UJ;
          result_src        = RES_PC4;
          reg_write         = 1'b1;
        end
        OP_JALR: begin
          pc_src        = 1'b1;
          pc_target_src = 1'b1;
          alu_src       = 1'b1;
          result_src    = RES_PC4;
          reg_write     = 1'b1;
        end
        OP_LUI: begin
          reg_write         = 1'b1;
          alu_src           = 1'b1;
          immediate_control = IMM_UJ;
          alu_control       = ALU_PASS;
        end
        OP_AUIPC: begin
          reg_write         = 1'b1;
          immediate_control = IMM_UJ;
          result_src        = RES_TGT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_decoder.sv
// Bench for rv32i_decoder: directed vector table, async-reset
// sequence and randomized checks against a reference model.
module tb_rv32i_decoder;

  typedef struct packed {
    logic       pc;
    logic       pts;
    logic [1:0] rs;
    logic       mw;
    logic [2:0] wd;
    logic [3:0] ac;
    logic       as;
    logic [1:0] im;
    logic       rw;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] ins;
    logic [2:0]  flg;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        equal, less_than, less_than_unsigned;
  out_t        got;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rv32i_decoder dut (
    .clk               (clk),
    .reset             (reset),
    .instruction       (instruction),
    .equal             (equal),
    .less_than         (less_than),
    .less_than_unsigned(less_than_unsigned),
    .pc_src            (got.pc),
    .pc_target_src     (got.pts),
    .result_src        (got.rs),
    .mem_write         (got.mw),
    .mem_width         (got.wd),
    .alu_control       (got.ac),
    .alu_src           (got.as),
    .immediate_control (got.im),
    .reg_write         (got.rw)
  );

  function automatic out_t mk(logic pc, logic pts, logic [1:0] rs,
                              logic mw, logic [2:0] wd, logic [3:0] ac,
                              logic as, logic [1:0] im, logic rw);
    out_t o;
    o = '{pc, pts, rs, mw, wd, ac, as, im, rw};
    return o;
  endfunction

  function automatic out_t safe();
    return mk(0, 0, 2'b00, 0, 3'b010, 4'b0000, 0, 2'b00, 0);
  endfunction

  // Reference: one instruction class at a time, straight from the ISA rules
  function automatic out_t model(logic rst, logic [31:0] ins,
                                 logic eq, logic lt, logic ltu);
    out_t o;
    logic [2:0] f3;
    logic shift_r, sub_ok;
    bit take;
    o = safe();
    f3 = ins[14:12];
    if (rst) return o;
    case (ins[6:0])
      7'h33: begin
        sub_ok = (f3 == 3'd0) || (f3 == 3'd5);
        o.rw = 1;
        o.ac = {sub_ok ? ins[30] : 1'b0, f3};
      end
      7'h13: begin
        shift_r = (f3 == 3'd5);
        o.rw = 1; o.as = 1;
        o.ac = {shift_r ? ins[30] : 1'b0, f3};
      end
      7'h03: begin o.rw = 1; o.as = 1; o.rs = 2'd1; o.wd = f3; end
      7'h23: begin o.mw = 1; o.as = 1; o.im = 2'd1; o.wd = f3; end
      7'h63: begin
        case (f3)
          3'd0: take = eq;
          3'd1: take = !eq;
          3'd4: take = lt;
          3'd5: take = !lt;
          3'd6: take = ltu;
          3'd7: take = !ltu;
          default: take = 0;
        endcase
        o.im = 2'd2; o.ac = 4'd8; o.pc = take;
      end
      7'h6F: begin o.pc = 1; o.im = 2'd3; o.rs = 2'd2; o.rw = 1; end
      7'h67: begin
        o.pc = 1; o.pts = 1; o.as = 1; o.rs = 2'd2; o.rw = 1;
      end
      7'h37: begin o.rw = 1; o.as = 1; o.im = 2'd3; o.ac = 4'hF; end
      7'h17: begin o.rw = 1; o.im = 2'd3; o.rs = 2'd3; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic drive(logic rst, logic [31:0] ins, logic [2:0] flg);
    @(negedge clk);
    reset = rst;
    instruction = ins;
    {equal, less_than, less_than_unsigned} = flg;
    #1;
  endtask

  task automatic check(string nm, out_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (ins %h rst %b)",
                  nm, got, exp, instruction, reset);
  endtask

  vec_t vt[$];

  initial begin
    logic [6:0] ops [11];
    logic [31:0] ins;
    logic [2:0] flg;
    logic rst;
    out_t e;

    reset = 1'b1;
    instruction = 32'h0;
    {equal, less_than, less_than_unsigned} = 3'b000;

    vt.push_back('{"reset_add", 1, 32'h00000033, 3'b000, safe()});
    vt.push_back('{"reset_jal", 1, 32'h0000006F, 3'b111, safe()});
    vt.push_back('{"reset_beq", 1, 32'h00208063, 3'b100, safe()});
    vt.push_back('{"sub", 0, 32'h40208033, 3'b000,
      mk(0, 0, 0, 0, 3'b010, 4'b1000, 0, 0, 1)});
    vt.push_back('{"add", 0, 32'h00208033, 3'b000,
      mk(0, 0, 0, 0, 3'b010, 4'b0000, 0, 0, 1)});
    vt.push_back('{"srai", 0, 32'h4010D093, 3'b000,
      mk(0, 0, 0, 0, 3'b010, 4'b1101, 1, 0, 1)});
    vt.push_back('{"addi_b30", 0, 32'h40008093, 3'b000,
      mk(0, 0, 0, 0, 3'b010, 4'b0000, 1, 0, 1)});
    vt.push_back('{"lw", 0, 32'h0000A083, 3'b000,
      mk(0, 0, 1, 0, 3'b010, 4'b0000, 1, 0, 1)});
    vt.push_back('{"lhu", 0, 32'h0000D083, 3'b000,
      mk(0, 0, 1, 0, 3'b101, 4'b0000, 1, 0, 1)});
    vt.push_back('{"sb", 0, 32'h00108023, 3'b000,
      mk(0, 0, 0, 1, 3'b000, 4'b0000, 1, 1, 0)});
    vt.push_back('{"beq_t", 0, 32'h00208063, 3'b100,
      mk(1, 0, 0, 0, 3'b010, 4'b1000, 0, 2, 0)});
    vt.push_back('{"beq_nt", 0, 32'h00208063, 3'b011,
      mk(0, 0, 0, 0, 3'b010, 4'b1000, 0, 2, 0)});
    vt.push_back('{"bgeu_t", 0, 32'h0020F063, 3'b110,
      mk(1, 0, 0, 0, 3'b010, 4'b1000, 0, 2, 0)});
    vt.push_back('{"blt_t", 0, 32'h0020C063, 3'b010,
      mk(1, 0, 0, 0, 3'b010, 4'b1000, 0, 2, 0)});
    vt.push_back('{"jal", 0, 32'h0000006F, 3'b000,
      mk(1, 0, 2, 0, 3'b010, 4'b0000, 0, 3, 1)});
    vt.push_back('{"jalr", 0, 32'h00008067, 3'b000,
      mk(1, 1, 2, 0, 3'b010, 4'b0000, 1, 0, 1)});
    vt.push_back('{"lui", 0, 32'h000010B7, 3'b000,
      mk(0, 0, 0, 0, 3'b010, 4'b1111, 1, 3, 1)});
    vt.push_back('{"auipc", 0, 32'h00001097, 3'b000,
      mk(0, 0, 3, 0, 3'b010, 4'b0000, 0, 3, 1)});
    vt.push_back('{"illegal", 0, 32'h0000007F, 3'b111, safe()});
    vt.push_back('{"fence", 0, 32'h0000000F, 3'b000, safe()});
    vt.push_back('{"ecall", 0, 32'h00000073, 3'b000, safe()});

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].ins, vt[i].flg);
      check(vt[i].name, vt[i].exp);
    end

    // funct3=010 branch is never taken, whatever the flags
    for (int f = 0; f < 8; f++) begin
      drive(0, 32'h0020A063, 3'(f));
      check("br_f3_010", mk(0, 0, 0, 0, 3'b010, 4'b1000, 0, 2, 0));
    end

    // reset acts between clock edges, no edge required
    drive(0, 32'h0000006F, 3'b000);
    check("jal_pre_rst", mk(1, 0, 2, 0, 3'b010, 4'b0000, 0, 3, 1));
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("async_rst_on", safe());
    #1 reset = 1'b0;
    #1 check("async_rst_off", mk(1, 0, 2, 0, 3'b010, 4'b0000, 0, 3, 1));

    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
            7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(9) != 0)
        ins[6:0] = ops[$urandom_range(10)];
      flg = 3'($urandom_range(7));
      rst = ($urandom_range(15) == 0);
      drive(rst, ins, flg);
      e = model(rst, ins, flg[2], flg[1], flg[0]);
      check("rand", e);
      n_total++;
      if (!(got.mw && got.rw)) n_pass++;
      else $display("FAIL mw_rw_excl: got mw=%b rw=%b required not both",
                    got.mw, got.rw);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
